// File: rtl/and_chk_pkg.sv
// +----------------------------------------------------------------------------+
// | and_chk_pkg : shared types and expected-result rule for and_resp_checker   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package and_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } chk_state_e;

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
   } op_pair_t;

   // A 2-bit operand counts as logically true when any bit is set.
   function automatic logic expected_result(input logic [1:0] a, input logic [1:0] b);
      return (a != 2'd0) && (b != 2'd0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/and_op_fifo.sv
// +----------------------------------------------------------------------------+
// | and_op_fifo : in-order operand queue, pointers carry one wrap bit          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module and_op_fifo
   import and_chk_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  logic     pop,
   input  op_pair_t din,
   output logic     full,
   output logic     empty,
   output op_pair_t head
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   op_pair_t    mem_q [DEPTH];
   op_pair_t    mem_d [DEPTH];

   // Same index with differing wrap bits means the writer has lapped the reader.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
      mem_q <= mem_d;
   end

endmodule

`default_nettype wire

// File: rtl/and_resp_checker.sv
// +----------------------------------------------------------------------------+
// | and_resp_checker : scoreboard comparing an AND DUT's y against its operands|
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module and_resp_checker
   import and_chk_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int CNT_W        = 16,
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [1:0]       a,
   input  logic [1:0]       b,
   input  logic             res_valid,
   input  logic             y,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             fail_pulse,
   output logic [1:0]       last_fail_a,
   output logic [1:0]       last_fail_b,
   output logic             underflow_err,
   output logic             overflow_err,
   output logic             halted
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   chk_state_e       state_q, state_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             fail_pulse_q, fail_pulse_d;
   logic [1:0]       last_fail_a_q, last_fail_a_d;
   logic [1:0]       last_fail_b_q, last_fail_b_d;
   logic             underflow_q, underflow_d;
   logic             overflow_q, overflow_d;

   logic     active;
   logic     fifo_push;
   logic     fifo_pop;
   logic     fifo_full;
   logic     fifo_empty;
   op_pair_t fifo_head;
   op_pair_t fifo_din;
   logic     mismatch;

   // op_ready depends only on flops so an upstream driver can use it freely.
   assign active    = (state_q != ST_HALT);
   assign op_ready  = active && !fifo_full;
   assign fifo_push = op_valid && op_ready;
   assign fifo_pop  = active && res_valid && !fifo_empty;
   assign fifo_din  = '{a: a, b: b};
   assign mismatch  = fifo_pop && (y != expected_result(fifo_head.a, fifo_head.b));

   and_op_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   always_comb begin
      state_d       = state_q;
      pass_cnt_d    = pass_cnt_q;
      fail_cnt_d    = fail_cnt_q;
      fail_pulse_d  = 1'b0;
      last_fail_a_d = last_fail_a_q;
      last_fail_b_d = last_fail_b_q;
      underflow_d   = underflow_q;
      overflow_d    = overflow_q;

      if (fifo_pop) begin
         if (!mismatch) begin
            if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_ONE;
         end else begin
            if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_ONE;
            fail_pulse_d  = 1'b1;
            last_fail_a_d = fifo_head.a;
            last_fail_b_d = fifo_head.b;
         end
      end

      // Empty is registered, so a push landing this same cycle still underflows.
      if (active && res_valid && fifo_empty) underflow_d = 1'b1;
      if (active && op_valid && !op_ready)   overflow_d  = 1'b1;

      case (state_q)
         ST_IDLE: if (fifo_push) state_d = ST_RUN;
         ST_RUN:  if (mismatch && STOP_ON_FAIL) state_d = ST_HALT;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pass_cnt_q    <= '0;
         fail_cnt_q    <= '0;
         fail_pulse_q  <= 1'b0;
         last_fail_a_q <= 2'd0;
         last_fail_b_q <= 2'd0;
         underflow_q   <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pass_cnt_q    <= pass_cnt_d;
         fail_cnt_q    <= fail_cnt_d;
         fail_pulse_q  <= fail_pulse_d;
         last_fail_a_q <= last_fail_a_d;
         last_fail_b_q <= last_fail_b_d;
         underflow_q   <= underflow_d;
         overflow_q    <= overflow_d;
      end
   end

   assign pass_cnt      = pass_cnt_q;
   assign fail_cnt      = fail_cnt_q;
   assign fail_pulse    = fail_pulse_q;
   assign last_fail_a   = last_fail_a_q;
   assign last_fail_b   = last_fail_b_q;
   assign underflow_err = underflow_q;
   assign overflow_err  = overflow_q;
   assign halted        = (state_q == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_and_resp_checker.sv
// +----------------------------------------------------------------------------+
// | tb_and_resp_checker : bench for and_resp_checker (default, narrow, halting)|
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_and_resp_checker;

   localparam int DEPTH = 4;

   logic       clk;
   logic       reset;
   logic       op_valid;
   logic [1:0] a;
   logic [1:0] b;
   logic       res_valid;
   logic       y;

   // Instance 0: defaults, 1: 2-bit counters, 2: stop on first mismatch.
   logic        rdy_m, rdy_s, rdy_h;
   logic [15:0] pass_m, fail_m, pass_h, fail_h;
   logic [1:0]  pass_s, fail_s;
   logic        pul_m, pul_s, pul_h;
   logic [1:0]  lfa_m, lfa_s, lfa_h, lfb_m, lfb_s, lfb_h;
   logic        unf_m, unf_s, unf_h, ovf_m, ovf_s, ovf_h;
   logic        hlt_m, hlt_s, hlt_h;

   and_resp_checker #(.DEPTH(DEPTH), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u_main (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(rdy_m), .a(a), .b(b),
      .res_valid(res_valid), .y(y), .pass_cnt(pass_m), .fail_cnt(fail_m),
      .fail_pulse(pul_m), .last_fail_a(lfa_m), .last_fail_b(lfb_m),
      .underflow_err(unf_m), .overflow_err(ovf_m), .halted(hlt_m));

   and_resp_checker #(.DEPTH(DEPTH), .CNT_W(2), .STOP_ON_FAIL(1'b0)) u_sat (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(rdy_s), .a(a), .b(b),
      .res_valid(res_valid), .y(y), .pass_cnt(pass_s), .fail_cnt(fail_s),
      .fail_pulse(pul_s), .last_fail_a(lfa_s), .last_fail_b(lfb_s),
      .underflow_err(unf_s), .overflow_err(ovf_s), .halted(hlt_s));

   and_resp_checker #(.DEPTH(DEPTH), .CNT_W(16), .STOP_ON_FAIL(1'b1)) u_stop (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(rdy_h), .a(a), .b(b),
      .res_valid(res_valid), .y(y), .pass_cnt(pass_h), .fail_cnt(fail_h),
      .fail_pulse(pul_h), .last_fail_a(lfa_h), .last_fail_b(lfb_h),
      .underflow_err(unf_h), .overflow_err(ovf_h), .halted(hlt_h));

   logic [31:0] o_ready [3];
   logic [31:0] o_pass  [3];
   logic [31:0] o_fail  [3];
   logic [31:0] o_pulse [3];
   logic [31:0] o_lfa   [3];
   logic [31:0] o_lfb   [3];
   logic [31:0] o_unf   [3];
   logic [31:0] o_ovf   [3];
   logic [31:0] o_halt  [3];

   assign o_ready[0] = 32'(rdy_m);  assign o_ready[1] = 32'(rdy_s);  assign o_ready[2] = 32'(rdy_h);
   assign o_pass[0]  = 32'(pass_m); assign o_pass[1]  = 32'(pass_s); assign o_pass[2]  = 32'(pass_h);
   assign o_fail[0]  = 32'(fail_m); assign o_fail[1]  = 32'(fail_s); assign o_fail[2]  = 32'(fail_h);
   assign o_pulse[0] = 32'(pul_m);  assign o_pulse[1] = 32'(pul_s);  assign o_pulse[2] = 32'(pul_h);
   assign o_lfa[0]   = 32'(lfa_m);  assign o_lfa[1]   = 32'(lfa_s);  assign o_lfa[2]   = 32'(lfa_h);
   assign o_lfb[0]   = 32'(lfb_m);  assign o_lfb[1]   = 32'(lfb_s);  assign o_lfb[2]   = 32'(lfb_h);
   assign o_unf[0]   = 32'(unf_m);  assign o_unf[1]   = 32'(unf_s);  assign o_unf[2]   = 32'(unf_h);
   assign o_ovf[0]   = 32'(ovf_m);  assign o_ovf[1]   = 32'(ovf_s);  assign o_ovf[2]   = 32'(ovf_h);
   assign o_halt[0]  = 32'(hlt_m);  assign o_halt[1]  = 32'(hlt_s);  assign o_halt[2]  = 32'(hlt_h);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (tag %0d) at %0t: got %0d, expected %0d", nm, tag, $time, act, exp);
      end
   endtask

   // Reference model: one operand queue plus per-instance counters and flags.
   logic [3:0]  mq [$];
   int unsigned m_pass [3];
   int unsigned m_fail [3];
   logic        m_pulse[3];
   logic [1:0]  m_lfa  [3];
   logic [1:0]  m_lfb  [3];
   logic        m_unf  [3];
   logic        m_ovf  [3];
   logic        m_halt [3];
   int unsigned m_max  [3] = '{65535, 3, 65535};
   logic        m_stop [3] = '{1'b0, 1'b0, 1'b1};

   task automatic model_update();
      logic       had;
      logic       room;
      logic [3:0] h;
      logic       ey;
      h  = 4'd0;
      ey = 1'b0;
      if (reset) begin
         mq.delete();
         for (int i = 0; i < 3; i++) begin
            m_pass[i] = 0; m_fail[i] = 0; m_pulse[i] = 0; m_lfa[i] = 0; m_lfb[i] = 0;
            m_unf[i] = 0; m_ovf[i] = 0; m_halt[i] = 0;
         end
         return;
      end
      had  = (mq.size() > 0);
      room = (mq.size() < DEPTH);
      if (res_valid && had) begin
         h  = mq.pop_front();
         ey = (h[3:2] != 0) && (h[1:0] != 0);
      end
      if (op_valid && room) mq.push_back({a, b});
      for (int i = 0; i < 3; i++) begin
         m_pulse[i] = 1'b0;
         if (!m_halt[i]) begin
            if (res_valid) begin
               if (!had) m_unf[i] = 1'b1;
               else if (y == ey) begin
                  if (m_pass[i] < m_max[i]) m_pass[i]++;
               end else begin
                  if (m_fail[i] < m_max[i]) m_fail[i]++;
                  m_pulse[i] = 1'b1;
                  m_lfa[i]   = h[3:2];
                  m_lfb[i]   = h[1:0];
                  if (m_stop[i]) m_halt[i] = 1'b1;
               end
            end
            if (op_valid && !room) m_ovf[i] = 1'b1;
         end
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < 3; i++) begin
         chk("mdl_op_ready", i, o_ready[i], 32'(!m_halt[i] && (mq.size() < DEPTH)));
         chk("mdl_pass_cnt", i, o_pass[i], m_pass[i]);
         chk("mdl_fail_cnt", i, o_fail[i], m_fail[i]);
         chk("mdl_fail_pulse", i, o_pulse[i], 32'(m_pulse[i]));
         chk("mdl_last_fail_a", i, o_lfa[i], 32'(m_lfa[i]));
         chk("mdl_last_fail_b", i, o_lfb[i], 32'(m_lfb[i]));
         chk("mdl_underflow", i, o_unf[i], 32'(m_unf[i]));
         chk("mdl_overflow", i, o_ovf[i], 32'(m_ovf[i]));
         chk("mdl_halted", i, o_halt[i], 32'(m_halt[i]));
      end
   endtask

   task automatic step(input logic r, input logic ov, input logic [1:0] aa, input logic [1:0] bb,
                       input logic rv, input logic yy);
      reset = r; op_valid = ov; a = aa; b = bb; res_valid = rv; y = yy;
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_model();
   endtask

   typedef struct {
      logic       rst, ov;
      logic [1:0] a, b;
      logic       rv, y;
      int         e_pass, e_fail;
      logic       e_pulse;
      logic [1:0] e_lfa, e_lfb;
      logic       e_unf, e_ovf, e_ready;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic ov, input logic [1:0] aa, input logic [1:0] bb,
                      input logic rv, input logic yy, input int ep, input int ef, input logic epl,
                      input logic [1:0] ela, input logic [1:0] elb, input logic eu, input logic eo,
                      input logic er);
      vec_t v;
      v.rst = rst; v.ov = ov; v.a = aa; v.b = bb; v.rv = rv; v.y = yy;
      v.e_pass = ep; v.e_fail = ef; v.e_pulse = epl; v.e_lfa = ela; v.e_lfb = elb;
      v.e_unf = eu; v.e_ovf = eo; v.e_ready = er;
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b1; op_valid = 1'b0; a = 2'd0; b = 2'd0; res_valid = 1'b0; y = 1'b0;

      //  rst ov a  b  rv y   pass fail pul lfa lfb unf ovf rdy
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 0, 1);   // result with nothing queued
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0, 1);   // 3&1 -> 1 matches
      add(0, 1, 0, 2, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 1, 1,  1, 1, 1, 0, 2, 0, 0, 1);   // 0&2 -> 0, y=1 mismatch
      add(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 0, 0, 1);
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 2, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 3, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 1, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);   // queue full
      add(0, 1, 3, 3, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);   // dropped operand
      add(0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 1, 1,  2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 1, 1,  3, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 1, 1,  4, 0, 0, 0, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 2, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);   // reset discards 3 queued
      add(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 0, 1);
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 1, 0, 1);   // push and result into empty
      add(0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 1, 0, 1);
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 1, 1);   // full: pop ok, push refused
      add(0, 0, 0, 0, 1, 1,  2, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 1, 1,  3, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 1, 1,  4, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 1, 1,  4, 0, 0, 0, 0, 1, 1, 1);   // refused operand never queued

      @(negedge clk);
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].ov, tbl[i].a, tbl[i].b, tbl[i].rv, tbl[i].y);
         chk("tbl_pass_cnt",   i, o_pass[0],  32'(tbl[i].e_pass));
         chk("tbl_fail_cnt",   i, o_fail[0],  32'(tbl[i].e_fail));
         chk("tbl_fail_pulse", i, o_pulse[0], 32'(tbl[i].e_pulse));
         chk("tbl_last_a",     i, o_lfa[0],   32'(tbl[i].e_lfa));
         chk("tbl_last_b",     i, o_lfb[0],   32'(tbl[i].e_lfb));
         chk("tbl_underflow",  i, o_unf[0],   32'(tbl[i].e_unf));
         chk("tbl_overflow",   i, o_ovf[0],   32'(tbl[i].e_ovf));
         chk("tbl_op_ready",   i, o_ready[0], 32'(tbl[i].e_ready));
      end

      // Stop-on-fail: mismatch halts, later correct results are ignored.
      step(1, 0, 0, 0, 0, 0);
      repeat (3) step(0, 1, 1, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("stop_halted_now", 2, o_halt[2], 32'd1);
      chk("stop_pulse_now",  2, o_pulse[2], 32'd1);
      chk("stop_ready_now",  2, o_ready[2], 32'd0);
      step(0, 0, 0, 0, 1, 1);
      step(0, 1, 2, 2, 1, 1);
      chk("stop_halted",   2, o_halt[2],  32'd1);
      chk("stop_fail_cnt", 2, o_fail[2],  32'd1);
      chk("stop_pass_cnt", 2, o_pass[2],  32'd0);
      chk("stop_op_ready", 2, o_ready[2], 32'd0);
      chk("stop_no_ovf",   2, o_ovf[2],   32'd0);
      chk("main_pass_cnt", 0, o_pass[0],  32'd2);

      // Saturation of 2-bit counters.
      step(1, 0, 0, 0, 0, 0);
      repeat (5) begin
         step(0, 1, 2, 2, 0, 0);
         step(0, 0, 0, 0, 1, 1);
      end
      repeat (5) begin
         step(0, 1, 0, 1, 0, 0);
         step(0, 0, 0, 0, 1, 1);
      end
      chk("sat_pass_cnt",  1, o_pass[1], 32'd3);
      chk("sat_fail_cnt",  1, o_fail[1], 32'd3);
      chk("wide_pass_cnt", 0, o_pass[0], 32'd5);
      chk("wide_fail_cnt", 0, o_fail[0], 32'd5);

      // Randomized traffic against the model, with occasional resets.
      step(1, 0, 0, 0, 0, 0);
      repeat (3000) begin
         step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 99) < 55),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/and_resp_checker.md
AND_RESP_CHECKER -- requirements
Module: and_resp_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning operand queue entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning pass/fail counter width.
REQ-003 SHALL have parameter STOP_ON_FAIL, default 0, meaning halt checking after first mismatch when 1.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
op_valid  input  1  operand pair presented to the DUT this cycle
op_ready  output  1  checker can accept an operand pair
a  input  2  operand a, as driven to the DUT
b  input  2  operand b, as driven to the DUT
res_valid  input  1  DUT result y valid this cycle
y  input  1  DUT result
pass_cnt  output  CNT_W  matched results
fail_cnt  output  CNT_W  mismatched results
fail_pulse  output  1  one-cycle pulse per mismatch
last_fail_a  output  2  operand a of most recent mismatch
last_fail_b  output  2  operand b of most recent mismatch
underflow_err  output  1  sticky: result arrived with no queued operand
overflow_err  output  1  sticky: op_valid while op_ready low
halted  output  1  state is HALT

Function
REQ-005 SHALL push {a,b} into an in-order FIFO when op_valid && op_ready.
REQ-006 SHALL drive op_ready = !full from registered state only (no combinational path from any input).
REQ-007 SHALL pop the FIFO head when res_valid && !empty, computing expected = (a!=0) && (b!=0) from the head.
REQ-008 SHALL increment pass_cnt when y == expected, else increment fail_cnt, assert fail_pulse, and load last_fail_a/b from the head; all updates visible one cycle after the res_valid edge.
REQ-009 SHALL saturate pass_cnt and fail_cnt at 2^CNT_W-1.
REQ-010 SHALL, on simultaneous push and pop, update both; occupancy unchanged; a push into a full FIFO is refused even if a pop occurs that cycle.
REQ-011 SHALL, on res_valid with FIFO empty (including same-cycle push into empty FIFO), set underflow_err, change no counter, and not pop.
REQ-012 SHALL set overflow_err on op_valid && !op_ready; the operand is dropped.
REQ-013 SHALL implement FSM IDLE -> RUN on first accepted push; RUN -> HALT on mismatch when STOP_ON_FAIL=1; HALT exits only on reset.
REQ-014 SHALL in HALT hold all counters and last_fail values, force op_ready low, ignore res_valid, and not set overflow_err or underflow_err.
REQ-015 SHALL wrap FIFO pointers modulo DEPTH with an extra bit for full/empty discrimination.

Reset
REQ-016 SHALL on reset clear FIFO pointers, pass_cnt, fail_cnt, fail_pulse, last_fail_a/b, underflow_err, overflow_err to 0; state IDLE; halted 0; op_ready 1 the following cycle.
REQ-017 SHALL on reset mid-operation discard queued operands without counting them.

Structure
REQ-018 SHALL place the state enum (IDLE, RUN, HALT) and the expected-result function in shared package and_chk_pkg.
REQ-019 SHALL implement the queue as sub-module and_op_fifo (push, pop, full, empty, head).

Verification
REQ-020 SHALL cover: push (a=3,b=1), then res_valid y=1 -> pass_cnt=1, fail_cnt=0 one cycle later.
REQ-021 SHALL cover: push (a=0,b=2), res_valid y=1 -> fail_cnt=1, fail_pulse one cycle, last_fail_a=0, last_fail_b=2.
REQ-022 SHALL cover: 4 pushes with no result -> op_ready=0; 5th op_valid -> overflow_err=1, later 4 correct results -> pass_cnt=4.
REQ-023 SHALL cover: res_valid after reset with nothing pushed -> underflow_err=1, pass_cnt=fail_cnt=0.
REQ-024 SHALL cover: STOP_ON_FAIL=1, mismatch then 2 further correct results -> halted=1, fail_cnt=1, pass_cnt unchanged, op_ready=0.
REQ-025 SHALL cover: 3 operands queued, reset asserted -> next cycle op_ready=1, counters 0, subsequent result -> underflow_err=1.
